// File: rtl/ulpi_rx_decode.sv
`default_nettype none
// ============================================================================
// Module   : ulpi_rx_decode
// Purpose  : Passive ULPI receive decoder that rebuilds UTMI RX signals and
//            per-packet length/completion strobes for the sniffer path.
// Revision : 1.0 - initial release
// ============================================================================
module ulpi_rx_decode #(
  parameter int LEN_W = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       ulpi_data_i,
  input  logic             ulpi_dir_i,
  input  logic             ulpi_nxt_i,
  output logic [7:0]       utmi_data_o,
  output logic             utmi_rxvalid_o,
  output logic             utmi_rxactive_o,
  output logic             utmi_rxerror_o,
  output logic [1:0]       utmi_linestate_o,
  output logic [1:0]       vbus_state_o,
  output logic             host_disconnect_o,
  output logic             rxcmd_stb_o,
  output logic             pkt_done_o,
  output logic [LEN_W-1:0] pkt_len_o,
  output logic             pkt_ovf_o,
  output logic             pkt_abort_o
);

  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_IDLE   = 2'd1,
    ST_TURN   = 2'd2,
    ST_BUS    = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] c_LEN_MAX = '1;

  state_t           r_state;
  logic [LEN_W-1:0] r_cnt;
  logic             r_ovf;

  logic w_turn;
  logic w_bus;
  logic w_fall;
  logic w_end;

  // Classify the current bus sample from the previous state and the live dir.
  assign w_turn = (r_state == ST_IDLE) && ulpi_dir_i;
  assign w_bus  = ((r_state == ST_TURN) || (r_state == ST_BUS)) && ulpi_dir_i;
  assign w_fall = ((r_state == ST_TURN) || (r_state == ST_BUS)) && !ulpi_dir_i;
  // RxEvent 00 and 10 both have bit 4 clear and drop rxactive.
  assign w_end  = utmi_rxactive_o &&
                  (w_fall || (w_bus && !ulpi_nxt_i && !ulpi_data_i[4]));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state           <= ST_RESYNC;
      r_cnt             <= '0;
      r_ovf             <= 1'b0;
      utmi_data_o       <= 8'h00;
      utmi_rxvalid_o    <= 1'b0;
      utmi_rxactive_o   <= 1'b0;
      utmi_rxerror_o    <= 1'b0;
      utmi_linestate_o  <= 2'b00;
      vbus_state_o      <= 2'b00;
      host_disconnect_o <= 1'b0;
      rxcmd_stb_o       <= 1'b0;
      pkt_done_o        <= 1'b0;
      pkt_len_o         <= '0;
      pkt_ovf_o         <= 1'b0;
      pkt_abort_o       <= 1'b0;
    end else begin
      utmi_rxvalid_o <= 1'b0;
      rxcmd_stb_o    <= 1'b0;
      pkt_done_o     <= 1'b0;

      case (r_state)
        ST_RESYNC: if (!ulpi_dir_i) r_state <= ST_IDLE;
        ST_IDLE:   if (ulpi_dir_i) r_state <= ST_TURN;
        default:   r_state <= ulpi_dir_i ? ST_BUS : ST_IDLE;
      endcase

      if (w_turn && ulpi_nxt_i) begin
        utmi_rxactive_o <= 1'b1;
        utmi_rxerror_o  <= 1'b0;
        r_cnt           <= '0;
        r_ovf           <= 1'b0;
      end

      if (w_bus && ulpi_nxt_i) begin
        utmi_data_o    <= ulpi_data_i;
        utmi_rxvalid_o <= 1'b1;
        if (!utmi_rxactive_o) begin
          utmi_rxactive_o <= 1'b1;
          utmi_rxerror_o  <= 1'b0;
          r_cnt           <= LEN_W'(1);
          r_ovf           <= 1'b0;
        end else if (r_cnt == c_LEN_MAX) begin
          r_ovf <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      if (w_bus && !ulpi_nxt_i) begin
        rxcmd_stb_o       <= 1'b1;
        utmi_linestate_o  <= ulpi_data_i[1:0];
        vbus_state_o      <= ulpi_data_i[3:2];
        host_disconnect_o <= (ulpi_data_i[5:4] == 2'b10);
        if (ulpi_data_i[4]) begin
          utmi_rxactive_o <= 1'b1;
          if (!utmi_rxactive_o) begin
            r_cnt          <= '0;
            r_ovf          <= 1'b0;
            utmi_rxerror_o <= 1'b0;
          end
          if (ulpi_data_i[5]) utmi_rxerror_o <= 1'b1;
        end
      end

      if (w_end) begin
        pkt_done_o      <= 1'b1;
        pkt_len_o       <= r_cnt;
        pkt_ovf_o       <= r_ovf;
        pkt_abort_o     <= w_fall;
        utmi_rxactive_o <= 1'b0;
        utmi_rxerror_o  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ulpi_rx_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_ulpi_rx_decode
// Purpose  : Scoreboard bench for ulpi_rx_decode at LEN_W=11 and LEN_W=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ulpi_rx_decode;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] data;
  logic       dir;
  logic       nxt;

  always #5 clk = ~clk;

  logic [7:0]  a_data, b_data;
  logic        a_rv, a_act, a_err, a_hd, a_cmd, a_done, a_ovf, a_ab;
  logic        b_rv, b_act, b_err, b_hd, b_cmd, b_done, b_ovf, b_ab;
  logic [1:0]  a_ls, a_vb, b_ls, b_vb;
  logic [10:0] a_len;
  logic [3:0]  b_len;

  ulpi_rx_decode #(.LEN_W(11)) dut (
    .clk_i(clk), .rst_i(rst_i), .ulpi_data_i(data), .ulpi_dir_i(dir), .ulpi_nxt_i(nxt),
    .utmi_data_o(a_data), .utmi_rxvalid_o(a_rv), .utmi_rxactive_o(a_act),
    .utmi_rxerror_o(a_err), .utmi_linestate_o(a_ls), .vbus_state_o(a_vb),
    .host_disconnect_o(a_hd), .rxcmd_stb_o(a_cmd), .pkt_done_o(a_done),
    .pkt_len_o(a_len), .pkt_ovf_o(a_ovf), .pkt_abort_o(a_ab)
  );

  ulpi_rx_decode #(.LEN_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst_i), .ulpi_data_i(data), .ulpi_dir_i(dir), .ulpi_nxt_i(nxt),
    .utmi_data_o(b_data), .utmi_rxvalid_o(b_rv), .utmi_rxactive_o(b_act),
    .utmi_rxerror_o(b_err), .utmi_linestate_o(b_ls), .vbus_state_o(b_vb),
    .host_disconnect_o(b_hd), .rxcmd_stb_o(b_cmd), .pkt_done_o(b_done),
    .pkt_len_o(b_len), .pkt_ovf_o(b_ovf), .pkt_abort_o(b_ab)
  );

  typedef struct packed {
    logic        rv;
    logic        cmd;
    logic        dn;
    logic [7:0]  d;
    logic        act;
    logic        err;
    logic [1:0]  ls;
    logic [1:0]  vb;
    logic        hd;
    logic [10:0] len;
    logic        ovf;
    logic        ab;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  logic [1:0] e_ls;
  logic [1:0] e_vb;
  logic       e_hd;

  // Fields that are only meaningful with their strobe are masked to zero.
  function automatic ev_t mk(input logic rv, input logic cmd, input logic dn,
                             input logic [7:0] d, input logic act, input logic err,
                             input logic [1:0] ls, input logic [1:0] vb, input logic hd,
                             input logic [10:0] len, input logic ovf, input logic ab);
    ev_t e;
    e.rv  = rv;
    e.cmd = cmd;
    e.dn  = dn;
    e.d   = rv ? d : 8'h00;
    e.act = act;
    e.err = err;
    e.ls  = ls;
    e.vb  = vb;
    e.hd  = hd;
    e.len = dn ? len : 11'd0;
    e.ovf = dn & ovf;
    e.ab  = dn & ab;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cmp_ev(input string name, input ev_t got, input ev_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_rv || a_cmd || a_done) begin
      if (qa.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL ev11 @%0t: unexpected event rv=%b cmd=%b done=%b", $time, a_rv, a_cmd, a_done);
      end else begin
        cmp_ev("ev11", mk(a_rv, a_cmd, a_done, a_data, a_act, a_err, a_ls, a_vb, a_hd,
                          a_len, a_ovf, a_ab), qa.pop_front());
      end
    end
    if (b_rv || b_cmd || b_done) begin
      if (qb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL ev4 @%0t: unexpected event rv=%b cmd=%b done=%b", $time, b_rv, b_cmd, b_done);
      end else begin
        cmp_ev("ev4", mk(b_rv, b_cmd, b_done, b_data, b_act, b_err, b_ls, b_vb, b_hd,
                         {7'd0, b_len}, b_ovf, b_ab), qb.pop_front());
      end
    end
  end

  task automatic cyc(input logic d_dir, input logic d_nxt, input logic [7:0] d);
    dir  = d_dir;
    nxt  = d_nxt;
    data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic dbyte(input logic [7:0] d, input logic err);
    qa.push_back(mk(1'b1, 1'b0, 1'b0, d, 1'b1, err, e_ls, e_vb, e_hd, 11'd0, 1'b0, 1'b0));
    qb.push_back(mk(1'b1, 1'b0, 1'b0, d, 1'b1, err, e_ls, e_vb, e_hd, 11'd0, 1'b0, 1'b0));
    cyc(1'b1, 1'b1, d);
  endtask

  task automatic cmd(input logic [7:0] d, input logic act, input logic err, input logic dn,
                     input logic [10:0] la, input logic oa, input logic [10:0] lb, input logic ob);
    e_ls = d[1:0];
    e_vb = d[3:2];
    e_hd = (d[5:4] == 2'b10);
    qa.push_back(mk(1'b0, 1'b1, dn, 8'h00, act, err, e_ls, e_vb, e_hd, la, oa, 1'b0));
    qb.push_back(mk(1'b0, 1'b1, dn, 8'h00, act, err, e_ls, e_vb, e_hd, lb, ob, 1'b0));
    cyc(1'b1, 1'b0, d);
  endtask

  task automatic fall(input logic dn, input logic [10:0] len);
    if (dn) begin
      qa.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, e_ls, e_vb, e_hd, len, 1'b0, 1'b1));
      qb.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, e_ls, e_vb, e_hd, len, 1'b0, 1'b1));
    end
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; dir = 1'b0; nxt = 1'b0; data = 8'h00;
    e_ls = 2'b00; e_vb = 2'b00; e_hd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a", 32'({a_data, a_rv, a_act, a_err, a_ls, a_vb, a_hd, a_cmd, a_done, a_len, a_ovf, a_ab}), 32'd0);
    chk("reset_b", 32'({b_data, b_rv, b_act, b_err, b_ls, b_vb, b_hd, b_cmd, b_done, b_len, b_ovf, b_ab}), 32'd0);
    rst_i = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);

    // Normal packet
    cyc(1'b1, 1'b1, 8'hFF);
    chk("act_after_turn", 32'(a_act), 32'd1);
    dbyte(8'hA5, 1'b0);
    dbyte(8'hC3, 1'b0);
    dbyte(8'h00, 1'b0);
    cmd(8'h01, 1'b0, 1'b0, 1'b1, 11'd3, 1'b0, 11'd3, 1'b0);
    fall(1'b0, 11'd0);
    cyc(1'b0, 1'b0, 8'h00);

    // Bus-idle RX CMDs, including a host-disconnect event
    cyc(1'b1, 1'b0, 8'hFF);
    cmd(8'h0D, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 11'd0, 1'b0);
    cmd(8'h02, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 11'd0, 1'b0);
    cmd(8'h20, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 11'd0, 1'b0);
    fall(1'b0, 11'd0);
    cyc(1'b0, 1'b0, 8'h00);
    chk("len_hold", 32'(a_len), 32'd3);

    // Error packet
    cyc(1'b1, 1'b1, 8'hFF);
    dbyte(8'h11, 1'b0);
    dbyte(8'h22, 1'b0);
    cmd(8'h30, 1'b1, 1'b1, 1'b0, 11'd0, 1'b0, 11'd0, 1'b0);
    dbyte(8'h33, 1'b1);
    cmd(8'h00, 1'b0, 1'b0, 1'b1, 11'd3, 1'b0, 11'd3, 1'b0);
    fall(1'b0, 11'd0);
    chk("err_clear", 32'(a_err), 32'd0);
    cyc(1'b0, 1'b0, 8'h00);

    // Abort by dir falling
    cyc(1'b1, 1'b1, 8'hFF);
    for (int i = 1; i <= 5; i++) dbyte(8'(i), 1'b0);
    fall(1'b1, 11'd5);
    chk("abort_act", 32'(a_act), 32'd0);
    cyc(1'b0, 1'b0, 8'h00);

    // Overflow: 20 bytes saturate only the 4-bit counter
    cyc(1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < 20; i++) dbyte(8'(8'h40 + i), 1'b0);
    cmd(8'h00, 1'b0, 1'b0, 1'b1, 11'd20, 1'b0, 11'd15, 1'b1);
    fall(1'b0, 11'd0);
    cyc(1'b0, 1'b0, 8'h00);

    // Implicit start on first data byte, RxEvent 01 keeps it active, then abort
    cyc(1'b1, 1'b0, 8'hFF);
    dbyte(8'h5A, 1'b0);
    dbyte(8'h6B, 1'b0);
    cmd(8'h11, 1'b1, 1'b0, 1'b0, 11'd0, 1'b0, 11'd0, 1'b0);
    fall(1'b1, 11'd2);
    cyc(1'b0, 1'b0, 8'h00);

    // Reset mid-packet, then resync while dir stays high
    cyc(1'b1, 1'b1, 8'hFF);
    dbyte(8'hAA, 1'b0);
    dbyte(8'hBB, 1'b0);
    rst_i = 1'b0;
    e_ls = 2'b00; e_vb = 2'b00; e_hd = 1'b0;
    cyc(1'b1, 1'b1, 8'hCC);
    cyc(1'b1, 1'b1, 8'hDD);
    chk("midrst_a", 32'({a_data, a_rv, a_act, a_err, a_ls, a_vb, a_hd, a_cmd, a_done, a_len, a_ovf, a_ab}), 32'd0);
    chk("midrst_b", 32'({b_data, b_rv, b_act, b_err, b_ls, b_vb, b_hd, b_cmd, b_done, b_len, b_ovf, b_ab}), 32'd0);
    rst_i = 1'b1;
    cyc(1'b1, 1'b0, 8'h01);
    cyc(1'b1, 1'b1, 8'h02);
    cyc(1'b1, 1'b0, 8'h03);
    cyc(1'b1, 1'b1, 8'h04);
    chk("resync_act", 32'(a_act), 32'd0);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'hFF);
    dbyte(8'h77, 1'b0);
    cmd(8'h00, 1'b0, 1'b0, 1'b1, 11'd1, 1'b0, 11'd1, 1'b0);
    fall(1'b0, 11'd0);

    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
